// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default widths for the multi-port register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write bits with NUM_RD lookup ports
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pend
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend;
    logic             set_ok;

    assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

    // Set is applied after clear so a same-cycle alloc to the written register wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            if (clr_en) pend[clr_addr] <= 1'b0;
            if (set_ok) pend[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_pend = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_pend[i] = en && pend[rd_addr[i*ADDR_W +: ADDR_W]]
                && !((BYPASS != 0) && clr_en
                     && (clr_addr == rd_addr[i*ADDR_W +: ADDR_W])
                     && !(set_en && (set_addr == rd_addr[i*ADDR_W +: ADDR_W])));
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with init sweep, bypass and hazard flags
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic                     ready
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic                ready_nxt;
    logic                run;
    logic                wr_ok;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign run   = (state == ST_RUN);
    assign wr_ok = run && we && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ready_nxt = ready;
        case (state)
            ST_INIT: begin
                idx_nxt = idx + ADDR_W'(1);
                if (idx == LAST_IDX) begin
                    state_nxt = ST_RUN;
                    ready_nxt = 1'b1;
                    idx_nxt   = '0;
                end
            end
            ST_RUN:  ready_nxt = 1'b1;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!run || ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_ok && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr)) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run),
        .set_en   (run && alloc_en),
        .set_addr (alloc_addr),
        .clr_en   (run && we),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .rd_pend  (rd_pend)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    regfile_mp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pend    (rd_pend),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Counts low-ready cycles after release; reads must stay zero and unflagged.
    task automatic wait_ready(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready) break;
            check("init_rd0", rd_data[31:0], 32'h0);
            check("init_pend", {30'h0, rd_pend}, 32'h0);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_pend", {30'h0, rd_pend}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        wait_ready(cnt);
        check("init_len", cnt, 32);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            check("sweep_p0", rd_data[31:0], 32'h0);
            check("sweep_p1", rd_data[63:32], 32'h0);
        end

        next_cycle();
        we = 1'b1; wr_addr = 5; wr_data = 32'h000964EB; set_rd(5, 3);
        @(negedge clk);
        check("byp_p0", rd_data[31:0], 32'h000964EB);
        check("byp_other_p1", rd_data[63:32], 32'h0);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("reg_p0", rd_data[31:0], 32'h000964EB);

        next_cycle();
        we = 1'b1; wr_addr = 0; wr_data = 32'hDEADBEEF; set_rd(0, 0);
        @(negedge clk);
        check("zero_byp_p0", rd_data[31:0], 32'h0);
        check("zero_byp_p1", rd_data[63:32], 32'h0);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("zero_p0", rd_data[31:0], 32'h0);
        check("zero_p1", rd_data[63:32], 32'h0);

        next_cycle();
        we = 1'b1; wr_addr = 9; wr_data = 32'h12345678; set_rd(9, 9);
        @(negedge clk);
        check("dup_byp_p0", rd_data[31:0], 32'h12345678);
        check("dup_byp_p1", rd_data[63:32], 32'h12345678);
        next_cycle();
        wr_addr = 31; wr_data = 32'hF00DF00D; set_rd(9, 5);
        @(negedge clk);
        check("indep_p0", rd_data[31:0], 32'h12345678);
        check("indep_p1", rd_data[63:32], 32'h000964EB);
        next_cycle();
        we = 1'b0; set_rd(31, 31);
        @(negedge clk);
        check("top_p0", rd_data[31:0], 32'hF00DF00D);
        check("top_p1", rd_data[63:32], 32'hF00DF00D);

        next_cycle();
        alloc_en = 1'b1; alloc_addr = 7; set_rd(7, 0);
        @(negedge clk);
        check("alloc_same_cyc", {30'h0, rd_pend}, 32'h0);
        next_cycle();
        alloc_en = 1'b0;
        @(negedge clk);
        check("alloc_pend", {30'h0, rd_pend}, 32'h1);
        next_cycle();
        we = 1'b1; wr_addr = 7; wr_data = 32'h00000077;
        @(negedge clk);
        check("wr_pend_byp", {30'h0, rd_pend}, 32'h0);
        check("wr_data_byp", rd_data[31:0], 32'h00000077);
        next_cycle();
        we = 1'b0;
        @(negedge clk);
        check("wr_pend_after", {30'h0, rd_pend}, 32'h0);
        next_cycle();
        alloc_en = 1'b1; alloc_addr = 7; we = 1'b1; wr_data = 32'h00000088; set_rd(7, 7);
        @(negedge clk);
        check("both_pend_now", {30'h0, rd_pend}, 32'h0);
        next_cycle();
        alloc_en = 1'b0; we = 1'b0;
        @(negedge clk);
        check("both_pend_after", {30'h0, rd_pend}, 32'h3);
        check("both_data", rd_data[31:0], 32'h00000088);
        next_cycle();
        alloc_en = 1'b1; alloc_addr = 0; set_rd(7, 0);
        next_cycle();
        alloc_en = 1'b0;
        @(negedge clk);
        check("zero_never_pend", {30'h0, rd_pend}, 32'h1);

        rst_n = 1'b0;
        #1;
        check("run_rst_ready", {31'h0, ready}, 32'h0);
        check("run_rst_pend", {30'h0, rd_pend}, 32'h0);
        we = 1'b1; wr_addr = 5; wr_data = 32'h00000BAD;
        alloc_en = 1'b1; alloc_addr = 6; set_rd(20, 6);
        next_cycle();
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'h0, ready}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        wait_ready(cnt);
        check("reinit_len", cnt, 32);
        we = 1'b0; alloc_en = 1'b0;
        #1;
        check("init_wr_ignored", rd_data[63:32], 32'h0);
        check("init_alloc_ignored", {30'h0, rd_pend}, 32'h0);
        set_rd(5, 7);
        #1;
        check("reinit_p0", rd_data[31:0], 32'h0);
        check("reinit_p1", rd_data[63:32], 32'h0);
        check("reinit_pend", {30'h0, rd_pend}, 32'h0);
        set_rd(31, 9);
        #1;
        check("reinit_top", rd_data[31:0], 32'h0);
        check("reinit_nine", rd_data[63:32], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 means register 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; 1 means same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port rd_pend  output  NUM_RD  per-port pending-write (hazard) flag.
REQ-011 SHALL have port we  input  1  write enable.
REQ-012 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-013 SHALL have port wr_data  input  DATA_W  write data.
REQ-014 SHALL have port alloc_en  input  1  mark a destination register as pending.
REQ-015 SHALL have port alloc_addr  input  ADDR_W  register to mark pending.
REQ-016 SHALL have port ready  output  1  high once initialisation sweep is complete.

Function
REQ-017 SHALL contain a two-state FSM: INIT and RUN.
REQ-018 In INIT, SHALL clear one register per cycle, sweeping index 0..DEPTH-1; after index DEPTH-1 is cleared, SHALL enter RUN on the next edge; INIT lasts exactly DEPTH cycles.
REQ-019 ready SHALL be 0 in INIT and 1 in RUN, driven from a flop.
REQ-020 In INIT, we and alloc_en SHALL be ignored, all rd_data SHALL read 0 and all rd_pend SHALL read 0.
REQ-021 In RUN, reads SHALL be combinational: rd_data[i] = register[rd_addr[i]].
REQ-022 In RUN, a write SHALL update register[wr_addr] on the rising edge when we=1; the new value SHALL be visible to the registered read path the following cycle.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0, and address 0 SHALL never be pending.
REQ-024 With BYPASS=1, when we=1 and rd_addr[i]==wr_addr (excluding address 0 under ZERO_REG), rd_data[i] SHALL equal wr_data in the same cycle.
REQ-025 SHALL keep one pending bit per register; alloc_en in RUN SHALL set pend[alloc_addr] at the next edge.
REQ-026 A write in RUN SHALL clear pend[wr_addr] at the next edge.
REQ-027 When alloc and write target the same address in the same cycle, the set SHALL win.
REQ-028 rd_pend[i] SHALL equal pend[rd_addr[i]]; with BYPASS=1, it SHALL be forced 0 when a same-cycle write to that address occurs without a same-cycle alloc to it.
REQ-029 All read ports SHALL operate independently; duplicate addresses across ports SHALL return identical data.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force the FSM to INIT, the sweep index to 0, ready to 0 and all pending bits to 0, including mid-sweep and mid-operation.
REQ-031 Register contents SHALL NOT be reset directly; the INIT sweep after rst_n deassertion SHALL zero them.

Structure
REQ-032 Package regfile_pkg SHALL hold the FSM state typedef (INIT, RUN) and default DATA_W/ADDR_W constants.
REQ-033 Pending-bit logic SHALL be sub-module regfile_scoreboard (alloc, clear, NUM_RD lookup ports).

Verification
REQ-034 Reset release -> ready=0 for exactly 32 cycles (defaults), then 1; every rd_data reads 0x00000000 after the sweep.
REQ-035 RUN, we=1, wr_addr=5, wr_data=0x000964EB, rd_addr port0=5 same cycle -> rd_data port0=0x000964EB same cycle (BYPASS=1) and on the following cycle.
REQ-036 Write 0xDEADBEEF to address 0 -> reading address 0 on both ports returns 0.
REQ-037 alloc_en to address 7, then rd_addr=7 -> rd_pend=1; write to 7 two cycles later -> rd_pend=0 in the write cycle (bypass) and thereafter; simultaneous alloc and write to 7 -> rd_pend=1 afterward.
REQ-038 Assert rst_n low at sweep index 10, then release -> ready stays 0 for a further full 32 cycles; pending bits all 0.
REQ-039 Any we/alloc_en during INIT -> no register or pending change observed after ready=1.
